// File: rtl/cpa_seq_pkg.sv
// Shared types and constants for the segmented sequential carry-propagate adder
// and the multiplier wrappers that instantiate it.
package cpa_seq_pkg;

  localparam int CPA_OP_W  = 28;
  localparam int CPA_SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Segment counter is sized for 0..nseg so the last index always fits.
  function automatic int seg_cnt_w(input int nseg);
    return (nseg < 1) ? 1 : $clog2(nseg + 1);
  endfunction

endpackage

// File: rtl/cpa_seg.sv
// Combinational W-bit Kogge-Stone prefix adder. The carry-in is folded into
// generate bit 0, so the prefix tree alone yields every carry including cout.
module cpa_seg #(
  parameter int W = 7
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_p;
  logic [W-1:0] w_gl, w_pl, w_gn, w_pn;
  logic [W:0]   w_c;

  always_comb begin
    w_p     = i_a ^ i_b;
    w_gl    = i_a & i_b;
    w_gl[0] = w_gl[0] | (w_p[0] & i_cin);
    w_pl    = w_p;
    w_gn    = w_gl;
    w_pn    = w_pl;
    for (int d = 1; d < W; d = d * 2) begin
      w_gn = w_gl;
      w_pn = w_pl;
      for (int i = d; i < W; i++) begin
        w_gn[i] = w_gl[i] | (w_pl[i] & w_gl[i-d]);
        w_pn[i] = w_pl[i] & w_pl[i-d];
      end
      w_gl = w_gn;
      w_pl = w_pn;
    end
  end

  // After the tree, w_gl[i] is the carry out of bit i.
  assign w_c    = {w_gl, i_cin};
  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];

endmodule

// File: rtl/cpa_seg_seq.sv
// Multi-cycle OP_W-bit adder: one SEG_W-bit prefix slice reused over NSEG cycles,
// LSB segment first, carry registered between segments, valid/ready on both sides.
module cpa_seg_seq
  import cpa_seq_pkg::*;
#(
  parameter int OP_W  = CPA_OP_W,
  parameter int SEG_W = CPA_SEG_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_sum,
  output logic            out_cout,
  output logic            busy
);

  localparam int NSEG = OP_W / SEG_W;
  localparam int CW   = seg_cnt_w(NSEG);

  if ((SEG_W < 1) || (OP_W < SEG_W) || ((OP_W % SEG_W) != 0)) begin : g_bad_cfg
    $error("cpa_seg_seq: OP_W must be a non-zero multiple of SEG_W");
  end

  state_t          r_state, w_state_nx;
  logic            r_armed;
  logic [CW-1:0]   r_seg_cnt;
  logic            r_carry;
  logic [OP_W-1:0] r_a_sh, r_b_sh;
  logic [OP_W-1:0] r_out_sum;
  logic            r_out_cout, r_out_valid, r_busy;
  logic [SEG_W-1:0] w_slice_sum;
  logic            w_slice_cout;
  logic [OP_W-1:0] w_sum_nx;
  logic            w_acc, w_last;

  // r_armed keeps in_ready low for the whole reset window, including cycle one.
  assign in_ready = (r_state == IDLE) && r_armed;
  assign w_acc    = in_valid && in_ready;
  assign w_last   = (r_seg_cnt == CW'(NSEG - 1));

  cpa_seg #(.W(SEG_W)) u_seg (
    .i_a    (r_a_sh[SEG_W-1:0]),
    .i_b    (r_b_sh[SEG_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Only the upper OP_W-SEG_W bits of the partial sum need storage; the newest
  // slice is concatenated on top combinationally.
  if (NSEG == 1) begin : g_one
    assign w_sum_nx = w_slice_sum;
  end else begin : g_multi
    logic [OP_W-SEG_W-1:0] r_sum_hi;
    always_ff @(posedge clk) begin
      if (rst)                r_sum_hi <= '0;
      else if (r_state == RUN) r_sum_hi <= w_sum_nx[OP_W-1:SEG_W];
    end
    assign w_sum_nx = {w_slice_sum, r_sum_hi};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_acc)     w_state_nx = RUN;
      RUN:     if (w_last)    w_state_nx = DONE;
      DONE:    if (out_ready) w_state_nx = IDLE;
      default:                w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_seg_cnt   <= '0;
      r_carry     <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_busy  <= (w_state_nx != IDLE);
      unique case (r_state)
        IDLE: if (w_acc) begin
          r_a_sh    <= in_a;
          r_b_sh    <= in_b;
          r_carry   <= in_cin;
          r_seg_cnt <= '0;
        end
        RUN: begin
          r_carry   <= w_slice_cout;
          r_a_sh    <= r_a_sh >> SEG_W;
          r_b_sh    <= r_b_sh >> SEG_W;
          r_seg_cnt <= r_seg_cnt + CW'(1);
          if (w_last) begin
            r_out_sum   <= w_sum_nx;
            r_out_cout  <= w_slice_cout;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cpa_seg_seq.sv
// Bench for cpa_seg_seq: vector table, hand sequences for latency, backpressure
// and mid-op reset, then randomized streams against an arithmetic reference.
module tb_cpa_seg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel7 = 1'b0;
  logic        in_valid = 1'b0;
  logic [27:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b1;

  logic        v28, r28, ov28, oc28, b28;
  logic [27:0] os28;
  logic        v7, r7, ov7, oc7, b7;
  logic [6:0]  os7;

  logic        g_ready, g_vld, g_cout, g_busy;
  logic [27:0] g_sum;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign v28 = in_valid & ~sel7;
  assign v7  = in_valid &  sel7;

  cpa_seg_seq #(.OP_W(28), .SEG_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(v28), .in_ready(r28),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(ov28), .out_ready(out_ready), .out_sum(os28), .out_cout(oc28), .busy(b28)
  );

  cpa_seg_seq #(.OP_W(7), .SEG_W(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(v7), .in_ready(r7),
    .in_a(in_a[6:0]), .in_b(in_b[6:0]), .in_cin(in_cin),
    .out_valid(ov7), .out_ready(out_ready), .out_sum(os7), .out_cout(oc7), .busy(b7)
  );

  assign g_ready = sel7 ? r7  : r28;
  assign g_vld   = sel7 ? ov7 : ov28;
  assign g_cout  = sel7 ? oc7 : oc28;
  assign g_busy  = sel7 ? b7  : b28;
  assign g_sum   = sel7 ? {21'd0, os7} : os28;

  typedef struct {
    logic [27:0] a;
    logic [27:0] b;
    logic        cin;
    logic [27:0] sum;
    logic        cout;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op with out_ready high; report result and accept->valid latency.
  task automatic run_op(input logic [27:0] a, input logic [27:0] b, input logic cin,
                        output logic [27:0] s, output logic c, output int lat);
    int t;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    t = 0;
    while (!g_ready && t < 40) begin tick(); t++; end
    if (!g_ready) chk("accept_timeout", 32'(g_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!g_vld && lat < 40) begin tick(); lat++; end
    s = g_sum;
    c = g_cout;
    tick();
  endtask

  task automatic stress(input int w, input int nops);
    longint q[$];
    longint mask, s, e;
    int sent, got, cyc;
    logic acc;
    mask = (64'd1 << w) - 1;
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    in_valid = 1'b0;
    while (got < nops && cyc < 40000) begin
      tick();
      cyc++;
      if (acc) begin in_valid = 1'b0; acc = 1'b0; end
      if (!in_valid && sent < nops && ($urandom % 4) != 0) begin
        in_a   = 28'($urandom) & 28'(mask);
        in_b   = 28'($urandom) & 28'(mask);
        in_cin = 1'($urandom);
        if (($urandom % 8) == 0) in_a = 28'(mask);
        in_valid = 1'b1;
      end
      if (in_valid && g_ready) begin
        s = longint'(in_a) + longint'(in_b) + longint'(in_cin);
        q.push_back(s);
        sent++;
        acc = 1'b1;
      end
      out_ready = (($urandom % 3) != 0);
      if (g_vld && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_sum",  32'(g_sum),  32'(e & mask));
          chk("rnd_cout", 32'(g_cout), 32'((e >> w) & 1));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rnd_all_outputs", 32'(got), 32'(nops));
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);
    repeat (8) tick();
    chk("rnd_no_stray_valid", 32'(g_vld), 32'd0);
  endtask

  initial begin
    logic [27:0] s, held;
    logic        c, heldc;
    int          lat, seen;

    tbl[0] = '{28'h0000001, 28'h0000002, 1'b0, 28'h0000003, 1'b0};
    tbl[1] = '{28'hFFFFFFF, 28'h0000000, 1'b1, 28'h0000000, 1'b1};
    tbl[2] = '{28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 28'hFFFFFFF, 1'b1};
    tbl[3] = '{28'h0000080, 28'h0000080, 1'b0, 28'h0000100, 1'b0};
    tbl[4] = '{28'h000007F, 28'h0000001, 1'b0, 28'h0000080, 1'b0};
    tbl[5] = '{28'h0003FFF, 28'h0000000, 1'b1, 28'h0004000, 1'b0};
    tbl[6] = '{28'h8000000, 28'h8000000, 1'b0, 28'h0000000, 1'b1};
    tbl[7] = '{28'h1234567, 28'h7654321, 1'b0, 28'h8888888, 1'b0};

    // Reset
    repeat (3) tick();
    chk("rst_in_ready",  32'(g_ready), 32'd0);
    chk("rst_out_valid", 32'(g_vld),   32'd0);
    chk("rst_out_sum",   32'(g_sum),   32'd0);
    chk("rst_out_cout",  32'(g_cout),  32'd0);
    chk("rst_busy",      32'(g_busy),  32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(g_ready), 32'd1);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, c, lat);
      chk($sformatf("vec%0d_sum", i),  32'(s),   32'(tbl[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(c),   32'(tbl[i].cout));
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'd4);
    end

    // Backpressure with a second op waiting on in_valid
    out_ready = 1'b0;
    in_a = 28'h1111111; in_b = 28'h2222222; in_cin = 1'b1; in_valid = 1'b1;
    chk("bp_ready_idle", 32'(g_ready), 32'd1);
    tick();
    in_a = 28'h0ABCDEF; in_b = 28'h0000011; in_cin = 1'b0;
    seen = 0;
    while (!g_vld && seen < 40) begin
      chk("bp_in_ready_run", 32'(g_ready), 32'd0);
      tick(); seen++;
    end
    chk("bp_lat", 32'(seen), 32'd4);
    held = g_sum; heldc = g_cout;
    chk("bp_sum",  32'(held),  32'h3333334);
    chk("bp_cout", 32'(heldc), 32'd0);
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 32'(g_vld),   32'd1);
      chk("bp_hold_sum",   32'(g_sum),   32'(held));
      chk("bp_hold_cout",  32'(g_cout),  32'(heldc));
      chk("bp_hold_ready", 32'(g_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_clear", 32'(g_vld),   32'd0);
    chk("bp_ready_again", 32'(g_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_busy", 32'(g_busy), 32'd1);
    seen = 0;
    while (!g_vld && seen < 40) begin tick(); seen++; end
    chk("bp_second_sum",  32'(g_sum),  32'h0ABCE00);
    chk("bp_second_cout", 32'(g_cout), 32'd0);
    tick();

    // Reset during the second RUN cycle abandons the op
    in_a = 28'hFFFFFFF; in_b = 28'h0000001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(g_busy), 32'd0);
    tick();
    chk("mid_rst_ready", 32'(g_ready), 32'd1);
    seen = 0;
    repeat (8) begin if (g_vld) seen++; tick(); end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);
    run_op(28'h1234567, 28'h7654321, 1'b0, s, c, lat);
    chk("mid_rst_next_sum",  32'(s), 32'h8888888);
    chk("mid_rst_next_cout", 32'(c), 32'd0);

    stress(28, 3000);

    // Single-segment instance
    sel7 = 1'b1;
    tick();
    run_op(28'h000007F, 28'h0000001, 1'b0, s, c, lat);
    chk("w7_sum",  32'(s),   32'h00);
    chk("w7_cout", 32'(c),   32'd1);
    chk("w7_lat",  32'(lat), 32'd1);
    stress(7, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
